// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared definitions for the EX-stage integer divider.
//   - div_state_e      : divider FSM state encodings (2 bits)
//   - RST_ENABLE       : reset level for this block (active-low)
//   - DIV_RESULT_*     : ready_o levels
//   - DIV_START/STOP   : start_i levels
//   - EXE_DIV(U)_OP    : aluop codes decoded by ID/EX for DIV and DIVU
package ex_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic RST_ENABLE           = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div_step.sv
// ex_div_step: one combinational radix-2 restoring division iteration.
// Ports:
//   partial_rem_i  : current partial remainder (always < divisor)
//   dividend_bit_i : next dividend bit, shifted in at the LSB
//   divisor_i      : divisor magnitude
//   new_rem_o      : partial remainder after this iteration
//   q_bit_o        : quotient bit produced by this iteration
module ex_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial_rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] new_rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {partial_rem_i, dividend_bit_i};
        // WIDTH+1-bit subtract: the top bit is the borrow, set when the
        // trial subtraction goes negative and the remainder is restored.
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[WIDTH];
        // The kept value always fits in WIDTH bits: it is below the divisor.
        new_rem_o = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring integer divider for the EX stage.
// One quotient bit per clock; signed (DIV) and unsigned (DIVU) modes.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous reset, active low
//   signed_div_i : 1 = signed divide, 0 = unsigned
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high by EX until ready_o is seen
//   annul_i      : cancel an in-flight division
//   result_o     : {remainder, quotient}, registered
//   ready_o      : result_o valid, registered
//   dbg_state_o  : current FSM state (div_state_e encoding)
// Handshake: a request is accepted on the edge where start_i=1 and annul_i=0
// in FREE. ready_o then stays high until start_i is sampled low (or annul_i
// high), at which edge the result is cleared; a new request needs one FREE
// cycle in between.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic [1:0]         dbg_state_o
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Holds the dividend magnitude; quotient bits shift in as dividend bits
    // shift out, so after WIDTH steps it holds the quotient magnitude.
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q_bit;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               op1_neg;
    logic               op2_neg;

    ex_div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem_i (rem_q),
        .dividend_bit_i(dvd_q[WIDTH-1]),
        .divisor_i     (dvs_q),
        .new_rem_o     (step_rem),
        .q_bit_o       (step_q_bit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg  = signed_div_i & opdata2_i[WIDTH-1];
        // Most-negative / -1 wraps naturally: magnitude 2**(W-1) stays as is.
        quot_fix = neg_quot_q ? (~dvd_q + 1'b1) : dvd_q;
        rem_fix  = neg_rem_q  ? (~rem_q + 1'b1) : rem_q;

        unique case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        rem_d      = '0;
                        dvd_d      = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
                        dvs_d      = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                    end
                end
            end
            DIV_BYZERO: begin
                result_d = '0;
                if (annul_i) begin
                    state_d = DIV_FREE;
                    ready_d = DIV_RESULT_NOT_READY;
                end else begin
                    state_d = DIV_END;
                    ready_d = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d  = DIV_END;
                    result_d = {rem_fix, quot_fix};
                    ready_d  = DIV_RESULT_READY;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_q_bit};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP || annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: self-checking bench for ex_div against an arithmetic reference.
module tb_ex_div;
    import ex_div_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic [1:0]     dbg_state_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_div #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .dbg_state_o (dbg_state_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation toward zero.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full request: latency, result, hold while start high, clear on drop.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          edges;
        int          lat;
        exp = model(sgn, a, b);
        lat = (b == 32'd0) ? 1 : 33;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        check("accept_state", {62'd0, dbg_state_o},
              (b == 32'd0) ? {62'd0, DIV_BYZERO} : {62'd0, DIV_ON});
        // Operands after acceptance must be ignored.
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        edges = 0;
        while (!ready_o && edges < 60) begin
            tick();
            edges++;
        end
        check("latency", 64'(edges), 64'(lat));
        check("result", result_o, exp);
        tick();
        check("hold_ready", {63'd0, ready_o}, 64'd1);
        check("hold_result", result_o, exp);
        start_i = 1'b0;
        tick();
        check("clr_ready", {63'd0, ready_o}, 64'd0);
        check("clr_result", result_o, 64'd0);
        check("clr_state", {62'd0, dbg_state_o}, {62'd0, DIV_FREE});
    endtask

    initial begin
        int rises;
        logic [31:0] a, b;
        bit sgn;

        rst = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        #12;
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_state", {62'd0, dbg_state_o}, {62'd0, DIV_FREE});
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Directed cases.
        run_div(1'b0, 32'h64, 32'h7);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2);
        run_div(1'b1, 32'h7, 32'hFFFF_FFFE);
        run_div(1'b0, 32'h1234, 32'h0);
        run_div(1'b1, 32'h8000_0000, 32'h0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        run_div(1'b0, 32'h5, 32'h9);

        // Annul in ON at cnt=10.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        repeat (10) tick();
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        check("annul_on_state", {62'd0, dbg_state_o}, {62'd0, DIV_FREE});
        check("annul_on_ready", {63'd0, ready_o}, 64'd0);
        check("annul_on_result", result_o, 64'd0);
        annul_i = 1'b0;
        rises = 0;
        repeat (40) begin
            tick();
            if (ready_o) rises++;
        end
        check("annul_no_ready", 64'(rises), 64'd0);

        // Annul in FREE blocks acceptance.
        start_i = 1'b1; annul_i = 1'b1; opdata2_i = 32'd3;
        tick();
        check("annul_free_state", {62'd0, dbg_state_o}, {62'd0, DIV_FREE});
        start_i = 1'b0; annul_i = 1'b0;
        tick();
        run_div(1'b0, 32'd9, 32'd3);

        // Annul in BYZERO.
        opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        tick();
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        check("annul_bz_state", {62'd0, dbg_state_o}, {62'd0, DIV_FREE});
        check("annul_bz_ready", {63'd0, ready_o}, 64'd0);
        annul_i = 1'b0;

        // Annul in END acts as start dropping.
        opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
        tick();
        rises = 0;
        while (!ready_o && rises < 60) begin tick(); rises++; end
        check("end_reach", {63'd0, ready_o}, 64'd1);
        annul_i = 1'b1;
        tick();
        check("annul_end_ready", {63'd0, ready_o}, 64'd0);
        check("annul_end_result", result_o, 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        tick();

        // Async reset mid-division at cnt=20: no clock edge before checking.
        opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        repeat (20) tick();
        #2 rst = 1'b0;
        #1;
        check("arst_on_state", {62'd0, dbg_state_o}, {62'd0, DIV_FREE});
        check("arst_on_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_div(1'b0, 32'h64, 32'h7);

        // Async reset while holding a result in END.
        opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
        tick();
        rises = 0;
        while (!ready_o && rises < 60) begin tick(); rises++; end
        check("end_reach2", result_o, model(1'b0, 32'd50, 32'd3));
        #2 rst = 1'b0;
        #1;
        check("arst_end_ready", {63'd0, ready_o}, 64'd0);
        check("arst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Randomized requests with a mix of operand shapes.
        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd0;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            run_div(sgn, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
